ball_motion_control: RTL and testbench

Ball physics and scoring for the two-player pong game on the 1024×768 / 65 MHz VGA pipeline. Holds the ball position, advances it once per frame, bounces it off the top and bottom walls and off both paddles, and counts points. In attract (idle) mode the ball bounces freely. Its position outputs feed the ball-drawing stage; its point counters feed the score display.

---
 rtl/ball_motion_control.sv | 150 +++++++++++++++
 tb/tb_ball_motion_control.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_control.sv
// Ball physics and scoring for two-player pong: per-frame ball step, wall and
// paddle bounces, miss detection with saturating scores, and attract-mode bounce.
module ball_motion_control (
   input  logic        clk65MHz,
   input  logic        rst,
   input  logic        end_of_frame,
   input  logic        serve,
   input  logic [9:0]  pos_of_player_1,
   input  logic [9:0]  pos_of_player_2,
   input  logic        screen_idle,
   input  logic        screen_multi,
   output logic [3:0]  points_player_1,
   output logic [3:0]  points_player_2,
   output logic [10:0] x_pos_of_ball,
   output logic [10:0] y_pos_of_ball
);

   typedef enum logic [1:0] {
      S_WAIT        = 2'd0,
      S_MOVE        = 2'd1,
      S_IDLE_BOUNCE = 2'd2
   } state_t;

   localparam logic [10:0] X_CENTRE = 11'd504;
   localparam logic [10:0] Y_CENTRE = 11'd376;

   state_t      r_state, w_state_nxt;
   logic [10:0] r_x, r_y, w_x_nxt, w_y_nxt;
   logic        r_dx, r_dy, w_dx_nxt, w_dy_nxt;
   logic [3:0]  r_pts1, r_pts2, w_pts1_nxt, w_pts2_nxt;
   logic        r_in_multi, w_in_multi_nxt;
   logic        w_hit_left, w_hit_right;
   logic [10:0] w_pad1_top, w_pad2_top;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'd15) ? v : v + 4'd1;
   endfunction

   assign w_pad1_top  = {1'b0, pos_of_player_1};
   assign w_pad2_top  = {1'b0, pos_of_player_2};
   assign w_hit_left  = (r_y + 11'd16 > w_pad1_top) && (r_y < w_pad1_top + 11'd128);
   assign w_hit_right = (r_y + 11'd16 > w_pad2_top) && (r_y < w_pad2_top + 11'd128);

   always_comb begin
      w_state_nxt    = r_state;
      w_x_nxt        = r_x;
      w_y_nxt        = r_y;
      w_dx_nxt       = r_dx;
      w_dy_nxt       = r_dy;
      w_pts1_nxt     = r_pts1;
      w_pts2_nxt     = r_pts2;
      w_in_multi_nxt = 1'b0;

      // Vertical step is shared by attract and game play; it is only committed on a frame tick.
      if (end_of_frame && (screen_idle || (r_in_multi && r_state == S_MOVE && screen_multi))) begin
         if (!r_dy && r_y <= 11'd4) begin
            w_y_nxt  = 11'd0;
            w_dy_nxt = 1'b1;
         end else if (r_dy && r_y >= 11'd748) begin
            w_y_nxt  = 11'd752;
            w_dy_nxt = 1'b0;
         end else begin
            w_y_nxt = r_dy ? r_y + 11'd4 : r_y - 11'd4;
         end
      end

      if (screen_idle) begin
         w_state_nxt = S_IDLE_BOUNCE;
         if (end_of_frame) begin
            if (!r_dx && r_x == 11'd0) begin
               w_dx_nxt = 1'b1;
            end else if (r_dx && r_x >= 11'd1008) begin
               w_x_nxt  = 11'd1008;
               w_dx_nxt = 1'b0;
            end else begin
               w_x_nxt = r_dx ? r_x + 11'd4 : r_x - 11'd4;
            end
         end
      end else if (screen_multi) begin
         w_in_multi_nxt = 1'b1;
         if (!r_in_multi || r_state == S_IDLE_BOUNCE) begin
            w_state_nxt = S_WAIT;
            w_x_nxt     = X_CENTRE;
            w_y_nxt     = Y_CENTRE;
            w_pts1_nxt  = 4'd0;
            w_pts2_nxt  = 4'd0;
         end else if (r_state == S_WAIT) begin
            if (serve) w_state_nxt = S_MOVE;
         end else if (end_of_frame) begin
            if (!r_dx && r_x <= 11'd36 && w_hit_left) begin
               w_x_nxt  = 11'd32;
               w_dx_nxt = 1'b1;
            end else if (r_dx && r_x >= 11'd972 && w_hit_right) begin
               w_x_nxt  = 11'd976;
               w_dx_nxt = 1'b0;
            end else if (!r_dx && r_x <= 11'd4) begin
               w_pts2_nxt  = sat_inc(r_pts2);
               w_state_nxt = S_WAIT;
               w_x_nxt     = X_CENTRE;
               w_y_nxt     = Y_CENTRE;
               w_dx_nxt    = 1'b0;
               w_dy_nxt    = 1'b1;
            end else if (r_dx && r_x >= 11'd1004) begin
               w_pts1_nxt  = sat_inc(r_pts1);
               w_state_nxt = S_WAIT;
               w_x_nxt     = X_CENTRE;
               w_y_nxt     = Y_CENTRE;
               w_dx_nxt    = 1'b1;
               w_dy_nxt    = 1'b1;
            end else begin
               w_x_nxt = r_dx ? r_x + 11'd4 : r_x - 11'd4;
            end
         end
      end else begin
         w_state_nxt = S_WAIT;
         w_x_nxt     = X_CENTRE;
         w_y_nxt     = Y_CENTRE;
         w_pts1_nxt  = 4'd0;
         w_pts2_nxt  = 4'd0;
      end
   end

   always_ff @(posedge clk65MHz) begin
      if (!rst) begin
         r_state    <= S_WAIT;
         r_x        <= X_CENTRE;
         r_y        <= Y_CENTRE;
         r_dx       <= 1'b1;
         r_dy       <= 1'b1;
         r_pts1     <= 4'd0;
         r_pts2     <= 4'd0;
         r_in_multi <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_x        <= w_x_nxt;
         r_y        <= w_y_nxt;
         r_dx       <= w_dx_nxt;
         r_dy       <= w_dy_nxt;
         r_pts1     <= w_pts1_nxt;
         r_pts2     <= w_pts2_nxt;
         r_in_multi <= w_in_multi_nxt;
      end
   end

   assign x_pos_of_ball   = r_x;
   assign y_pos_of_ball   = r_y;
   assign points_player_1 = r_pts1;
   assign points_player_2 = r_pts2;

endmodule

// File: tb/tb_ball_motion_control.sv
// Bench for ball_motion_control: vector table, directed rally/miss/attract
// sequences and a randomized run, all checked against a rule-level model.
module tb_ball_motion_control;

   logic        clk65MHz = 1'b0;
   logic        rst = 1'b0;
   logic        end_of_frame = 1'b0;
   logic        serve = 1'b0;
   logic [9:0]  pos_of_player_1 = 10'd377;
   logic [9:0]  pos_of_player_2 = 10'd377;
   logic        screen_idle = 1'b0;
   logic        screen_multi = 1'b1;
   logic [3:0]  points_player_1, points_player_2;
   logic [10:0] x_pos_of_ball, y_pos_of_ball;

   ball_motion_control dut (
      .clk65MHz        (clk65MHz),
      .rst             (rst),
      .end_of_frame    (end_of_frame),
      .serve           (serve),
      .pos_of_player_1 (pos_of_player_1),
      .pos_of_player_2 (pos_of_player_2),
      .screen_idle     (screen_idle),
      .screen_multi    (screen_multi),
      .points_player_1 (points_player_1),
      .points_player_2 (points_player_2),
      .x_pos_of_ball   (x_pos_of_ball),
      .y_pos_of_ball   (y_pos_of_ball)
   );

   always #5 clk65MHz = ~clk65MHz;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: phase 0 waiting, 1 in play, 2 attract.
   int mx, my, mdx, mdy, ms1, ms2, mph, m_game;

   function automatic bit overlaps(input int y, input int p);
      return (y + 16 > p) && (y < p + 128);
   endfunction

   task automatic centre_ball();
      mx = 504;
      my = 376;
   endtask

   task automatic model_vertical();
      if (mdy == 0 && my <= 4) begin my = 0; mdy = 1; end
      else if (mdy == 1 && my >= 748) begin my = 752; mdy = 0; end
      else my = (mdy == 1) ? my + 4 : my - 4;
   endtask

   task automatic model_edge(input bit r, eof, srv, idle, multi, input int p1, p2);
      int ox, oy;
      if (!r) begin
         centre_ball(); ms1 = 0; ms2 = 0; mdx = 1; mdy = 1; mph = 0; m_game = 0;
      end else if (idle) begin
         mph = 2; m_game = 0;
         if (eof) begin
            model_vertical();
            if (mdx == 0 && mx <= 0) begin mx = 0; mdx = 1; end
            else if (mdx == 1 && mx >= 1008) begin mx = 1008; mdx = 0; end
            else mx = (mdx == 1) ? mx + 4 : mx - 4;
         end
      end else if (!multi) begin
         centre_ball(); ms1 = 0; ms2 = 0; mph = 0; m_game = 0;
      end else if (!m_game) begin
         m_game = 1; centre_ball(); ms1 = 0; ms2 = 0; mph = 0;
      end else if (mph == 0) begin
         if (srv) mph = 1;
      end else if (eof) begin
         ox = mx; oy = my;
         model_vertical();
         if (mdx == 0 && ox <= 36 && overlaps(oy, p1)) begin mx = 32; mdx = 1; end
         else if (mdx == 1 && ox >= 972 && overlaps(oy, p2)) begin mx = 976; mdx = 0; end
         else if (mdx == 0 && ox <= 4) begin
            ms2 = (ms2 < 15) ? ms2 + 1 : 15; centre_ball(); mph = 0; mdx = 0; mdy = 1;
         end else if (mdx == 1 && ox >= 1004) begin
            ms1 = (ms1 < 15) ? ms1 + 1 : 15; centre_ball(); mph = 0; mdx = 1; mdy = 1;
         end else mx = (mdx == 1) ? mx + 4 : mx - 4;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic apply(input bit r, eof, srv, idle, multi, input int p1, p2);
      rst = r; end_of_frame = eof; serve = srv; screen_idle = idle; screen_multi = multi;
      pos_of_player_1 = 10'(p1); pos_of_player_2 = 10'(p2);
      @(posedge clk65MHz);
      model_edge(r, eof, srv, idle, multi, p1, p2);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".x"}, int'(x_pos_of_ball), mx);
      chk({tag, ".y"}, int'(y_pos_of_ball), my);
      chk({tag, ".p1"}, int'(points_player_1), ms1);
      chk({tag, ".p2"}, int'(points_player_2), ms2);
   endtask

   task automatic step(input string tag, input bit r, eof, srv, idle, multi, input int p1, p2);
      apply(r, eof, srv, idle, multi, p1, p2);
      check_model(tag);
   endtask

   function automatic int catch_pad(input int y);
      return (y < 50) ? 0 : y - 50;
   endfunction

   function automatic int avoid_pad(input int y);
      return (y < 400) ? 640 : 0;
   endfunction

   typedef struct {
      bit r, eof, srv, idle, multi;
      int p1, p2, ex, ey, e1, e2;
   } vec_t;

   initial begin
      vec_t tbl[10];
      int   sx, sy;
      bit   saw_l, saw_r, saw_t, saw_b;
      bit   cur_idle, cur_multi;

      tbl[0] = '{0, 0, 0, 0, 1, 377, 377, 504, 376, 0, 0};
      tbl[1] = '{1, 1, 0, 0, 1, 377, 377, 504, 376, 0, 0};
      tbl[2] = '{1, 1, 0, 0, 1, 377, 377, 504, 376, 0, 0};
      tbl[3] = '{1, 0, 1, 0, 1, 377, 377, 504, 376, 0, 0};
      tbl[4] = '{1, 1, 0, 0, 1, 377, 377, 508, 380, 0, 0};
      tbl[5] = '{1, 1, 0, 0, 1, 377, 377, 512, 384, 0, 0};
      tbl[6] = '{1, 0, 0, 0, 1, 377, 377, 512, 384, 0, 0};
      tbl[7] = '{1, 1, 1, 0, 1, 377, 377, 516, 388, 0, 0};
      tbl[8] = '{0, 1, 0, 0, 1, 377, 377, 504, 376, 0, 0};
      tbl[9] = '{1, 1, 0, 0, 1, 377, 377, 504, 376, 0, 0};
      for (int i = 0; i < 10; i++) begin
         apply(tbl[i].r, tbl[i].eof, tbl[i].srv, tbl[i].idle, tbl[i].multi, tbl[i].p1, tbl[i].p2);
         chk($sformatf("tbl%0d.x", i), int'(x_pos_of_ball), tbl[i].ex);
         chk($sformatf("tbl%0d.y", i), int'(y_pos_of_ball), tbl[i].ey);
         chk($sformatf("tbl%0d.p1", i), int'(points_player_1), tbl[i].e1);
         chk($sformatf("tbl%0d.p2", i), int'(points_player_2), tbl[i].e2);
      end

      // Serve, rally down to the bottom wall, then a right-paddle return.
      step("serve", 1, 1, 1, 0, 1, 377, 377);
      for (int i = 1; i <= 94; i++) step("rally", 1, 1, 0, 0, 1, 377, 377);
      chk("bottom.y", int'(y_pos_of_ball), 752);
      chk("bottom.x", int'(x_pos_of_ball), 880);
      step("rally", 1, 1, 0, 0, 1, 377, 377);
      chk("bounce.y", int'(y_pos_of_ball), 748);
      for (int i = 96; i <= 118; i++) step("rpad", 1, 1, 0, 0, 1, 377, 600);
      chk("rpad.x", int'(x_pos_of_ball), 976);
      chk("rpad.p1", int'(points_player_1), 0);
      step("rpad", 1, 1, 0, 0, 1, 377, 600);
      chk("rpad.ret", int'(x_pos_of_ball), 972);

      // Left player misses: point to player 2.
      for (int i = 0; i < 400 && mph == 1; i++) step("lmiss", 1, 1, 0, 0, 1, avoid_pad(my), 600);
      chk("lmiss.p2", int'(points_player_2), 1);
      chk("lmiss.x", int'(x_pos_of_ball), 504);
      chk("lmiss.y", int'(y_pos_of_ball), 376);
      for (int i = 0; i < 3; i++) step("hold", 1, 1, 0, 0, 1, 377, 377);
      chk("hold.x", int'(x_pos_of_ball), 504);
      step("serve2", 1, 1, 1, 0, 1, 377, 377);
      step("serve2", 1, 1, 0, 0, 1, 377, 377);
      chk("serve2.x", int'(x_pos_of_ball), 500);

      // Right player misses: point to player 1.
      for (int i = 0; i < 1200 && mph == 1; i++)
         step("rmiss", 1, 1, 0, 0, 1, catch_pad(my), avoid_pad(my));
      chk("rmiss.p1", int'(points_player_1), 1);
      step("serve3", 1, 0, 1, 0, 1, 377, 377);
      step("serve3", 1, 1, 0, 0, 1, 377, 377);
      chk("serve3.x", int'(x_pos_of_ball), 508);

      // Frame tick held low freezes the ball.
      sx = mx; sy = my;
      for (int i = 0; i < 5; i++) step("frz", 1, 0, i[0], 0, 1, 377, 377);
      chk("frz.x", int'(x_pos_of_ball), sx);
      chk("frz.y", int'(y_pos_of_ball), sy);

      // Attract mode: free bounce, scores frozen, then back to a fresh game.
      saw_l = 0; saw_r = 0; saw_t = 0; saw_b = 0;
      for (int i = 0; i < 800; i++) begin
         step("idle", 1, ($urandom_range(0, 9) != 0), $urandom_range(0, 1), 1, $urandom_range(0, 1),
              $urandom_range(0, 1023), $urandom_range(0, 1023));
         if (mx == 0) saw_l = 1;
         if (mx == 1008) saw_r = 1;
         if (my == 0) saw_t = 1;
         if (my == 752) saw_b = 1;
      end
      chk("idle.walls", int'({saw_l, saw_r, saw_t, saw_b}), 15);
      chk("idle.p1", int'(points_player_1), 1);
      chk("idle.p2", int'(points_player_2), 1);
      step("remulti", 1, 1, 1, 0, 1, 377, 377);
      chk("remulti.x", int'(x_pos_of_ball), 504);
      chk("remulti.y", int'(y_pos_of_ball), 376);
      chk("remulti.pts", int'({points_player_1, points_player_2}), 0);

      // Reset in mid-flight.
      step("mid", 1, 1, 1, 0, 1, 377, 377);
      for (int i = 0; i < 7; i++) step("mid", 1, 1, 0, 0, 1, 377, 377);
      step("midrst", 0, 1, 0, 0, 1, 377, 377);
      chk("midrst.x", int'(x_pos_of_ball), 504);
      chk("midrst.y", int'(y_pos_of_ball), 376);

      // Randomized run against the model.
      cur_idle = 0; cur_multi = 1;
      for (int i = 0; i < 4000; i++) begin
         int p1, p2;
         if ($urandom_range(0, 199) == 0) begin
            cur_idle  = ($urandom_range(0, 3) == 0);
            cur_multi = ($urandom_range(0, 4) != 0);
         end
         p1 = ($urandom_range(0, 2) != 0) ? catch_pad(my) : $urandom_range(0, 1023);
         p2 = ($urandom_range(0, 2) != 0) ? catch_pad(my) : $urandom_range(0, 1023);
         step("rnd", ($urandom_range(0, 299) != 0), ($urandom_range(0, 9) < 7),
              ($urandom_range(0, 9) == 0), cur_idle, cur_multi, p1, p2);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
